pixel_clock_divider: RTL

Parametrised successor to the fixed 50 MHz to 25 MHz pixel clock divider. It divides clk50M by a runtime-programmable integer ratio N and produces two outputs: a registered divided clock, clk_out, and a one-cycle clock-enable pulse, tick. Ratio changes are applied only at period boundaries, so clk_out never glitches. Downstream VGA timing runs on clk50M and qualifies its logic with tick.

---
 rtl/pixel_clock_divider.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pixel_clock_divider.sv
// Runtime-programmable integer clock divider producing clk_out and a tick enable.
// Optional lock indicator enabled by defining PIXEL_CLOCK_DIVIDER_LOCKED_EN.
module pixel_clock_divider #(
    parameter int DIV_W        = 8,
    parameter int DEFAULT_DIV  = 2
`ifdef PIXEL_CLOCK_DIVIDER_LOCKED_EN
   ,parameter int LOCK_PERIODS = 4
`endif
) (
    input  logic             clk50M,
    input  logic             reset,
    input  logic             en,
    input  logic [DIV_W-1:0] div_sel,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic [DIV_W-1:0] div_active,
    output logic             pending
`ifdef PIXEL_CLOCK_DIVIDER_LOCKED_EN
   ,output logic             locked
`endif
);

    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0] DEF     = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] CNT_RST = (DEF <= ONE) ? '0 : DEF - ONE;

    typedef enum logic {RUN, PEND} state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] act_q, act_d;
    logic [DIV_W-1:0] pval_q, pval_d;
    logic [DIV_W-1:0] n_cur, high_len;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             wrap, apply;

    // Ratios 0 and 1 both collapse to a divide-by-one
    function automatic logic [DIV_W-1:0] eff_n(input logic [DIV_W-1:0] v);
        return (v <= ONE) ? ONE : v;
    endfunction

    always_comb begin
        n_cur    = eff_n(act_q);
        high_len = n_cur - (n_cur >> 1);
        wrap     = en && (cnt_q == n_cur - ONE);
        apply    = wrap && ((state_q == PEND) || div_load);
        state_d  = state_q;
        act_d    = act_q;
        pval_d   = pval_q;
        cnt_d    = cnt_q;
        clk_d    = clk_q;
        tick_d   = 1'b0;
        if (apply) begin
            act_d   = div_load ? div_sel : pval_q;
            state_d = RUN;
        end else if (div_load) begin
            pval_d  = div_sel;
            state_d = PEND;
        end
        // A new ratio always starts at cnt 0, so the old ratio is safe for the compare
        if (en) begin
            cnt_d  = wrap ? '0 : cnt_q + ONE;
            clk_d  = cnt_d < high_len;
            tick_d = cnt_d == '0;
        end
    end

    always_ff @(posedge clk50M) begin
        if (!reset) begin
            state_q <= RUN;
            cnt_q   <= CNT_RST;
            act_q   <= DEF;
            pval_q  <= DEF;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            pval_q  <= pval_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
        end
    end

    assign clk_out    = clk_q;
    assign tick       = tick_q;
    assign div_active = act_q;
    assign pending    = (state_q == PEND);

`ifdef PIXEL_CLOCK_DIVIDER_LOCKED_EN
    localparam int LW = (LOCK_PERIODS < 1) ? 1 : $clog2(LOCK_PERIODS + 1);
    localparam logic [LW-1:0] LP = LW'(LOCK_PERIODS);

    logic [LW-1:0] pc_q, pc_d;
    logic          lk_q, lk_d;

    always_comb begin
        pc_d = pc_q;
        lk_d = lk_q;
        if (apply) begin
            pc_d = '0;
            lk_d = 1'b0;
        end else if (wrap) begin
            if (pc_q != LP) pc_d = pc_q + LW'(1);
            lk_d = (pc_d == LP);
        end
    end

    always_ff @(posedge clk50M) begin
        if (!reset) begin
            pc_q <= '0;
            lk_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            lk_q <= lk_d;
        end
    end

    assign locked = lk_q;
`endif

endmodule
